// File: rtl/gpr_seq_pkg.sv
// Shared types and constants for the gpr_seq execution sequencer.
// The optional multiplier is enabled with `define GPR_SEQ_MUL_EN.
package gpr_seq_pkg;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 4;

`ifdef GPR_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LDI = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_e;

    function automatic logic op_legal(input op_e op);
        return MUL_EN || (op != OP_MUL);
    endfunction

endpackage

// File: rtl/gpr_seq_if.sv
// Instruction handshake plus register-file port of the sequencer.
// slave is the sequencer side, master the producer/register-file side.
interface gpr_seq_if;

    logic                          in_valid;
    logic                          in_ready;
    logic [2:0]                    op;
    logic [gpr_seq_pkg::ADDR_W-1:0] rd;
    logic [gpr_seq_pkg::ADDR_W-1:0] rs;
    logic [gpr_seq_pkg::DATA_W-1:0] imm;
    logic [gpr_seq_pkg::ADDR_W-1:0] gpr_addr;
    logic                          gpr_read;
    logic                          gpr_write;
    logic [gpr_seq_pkg::DATA_W-1:0] gpr_wdata;
    logic [gpr_seq_pkg::DATA_W-1:0] gpr_rdata;
    logic                          done;
    logic                          err;
    logic                          flag_z;
    logic                          flag_c;

    modport slave (
        input  in_valid, op, rd, rs, imm, gpr_rdata,
        output in_ready, gpr_addr, gpr_read, gpr_write, gpr_wdata,
               done, err, flag_z, flag_c
    );

    modport master (
        output in_valid, op, rd, rs, imm, gpr_rdata,
        input  in_ready, gpr_addr, gpr_read, gpr_write, gpr_wdata,
               done, err, flag_z, flag_c
    );

endinterface

// File: rtl/gpr_seq_alu.sv
// Combinational datapath of gpr_seq: 10-bit result and carry/borrow.
// The multiplier exists only when GPR_SEQ_MUL_EN is defined.
module gpr_seq_alu
    import gpr_seq_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              c
);

    logic [DATA_W:0] ext;

    always_comb begin
        result = '0;
        c      = 1'b0;
        ext    = '0;
        case (op)
            OP_MOV: result = b;
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                result = ext[DATA_W-1:0];
                c      = ext[DATA_W];
            end
            // bit 10 of the 11-bit difference is the borrow (a < b)
            OP_SUB: begin
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[DATA_W-1:0];
                c      = ext[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_LDI: result = imm;
`ifdef GPR_SEQ_MUL_EN
            OP_MUL: result = a * b;
`else
            OP_MUL: result = '0;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/gpr_seq.sv
// Multi-cycle sequencer: reads operands over the shared register-file port,
// executes, writes back, and keeps Z/C flags. MUL gated by GPR_SEQ_MUL_EN.
module gpr_seq
    import gpr_seq_pkg::*;
#(
    parameter int NREGS = 10
) (
    input  logic      clk,
    input  logic      rst,
    gpr_seq_if.slave  bus
);

    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_RD_A = RD_A;
    localparam logic [2:0] S_RD_B = RD_B;
    localparam logic [2:0] S_EXEC = EXEC;
    localparam logic [2:0] S_WB   = WB;

    localparam logic [ADDR_W:0] NREGS_W = (ADDR_W+1)'(NREGS);

    logic [2:0]        state, state_nxt;
    op_e               op_q;
    logic [ADDR_W-1:0] rd_q, rs_q;
    logic [DATA_W-1:0] imm_q, a_q, b_q, res_q;
    logic              abort_q;
    logic              flag_z, flag_c;

    op_e               op_in;
    logic              accept, reject;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    assign op_in  = op_e'(bus.op);
    assign accept = (state == S_IDLE) && bus.in_valid;
    // LDI never reads rs, so only rd is range-checked for it
    assign reject = ({1'b0, bus.rd} >= NREGS_W)
                 || ((op_in != OP_LDI) && ({1'b0, bus.rs} >= NREGS_W))
                 || !op_legal(op_in);

    gpr_seq_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .result (alu_res),
        .c      (alu_c)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.in_valid) begin
                if (reject)                state_nxt = S_WB;
                else if (op_in == OP_LDI)  state_nxt = S_EXEC;
                else if (op_in == OP_MOV)  state_nxt = S_RD_B;
                else                       state_nxt = S_RD_A;
            end
            S_RD_A:  state_nxt = S_RD_B;
            S_RD_B:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= OP_MOV;
            rd_q    <= '0;
            rs_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            abort_q <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= op_in;
                rd_q    <= bus.rd;
                rs_q    <= bus.rs;
                imm_q   <= bus.imm;
                abort_q <= reject;
            end
            if (state == S_RD_A) a_q <= bus.gpr_rdata;
            if (state == S_RD_B) b_q <= bus.gpr_rdata;
            if (state == S_EXEC) begin
                res_q <= alu_res;
                if (op_q != OP_MOV && op_q != OP_LDI) begin
                    flag_z <= (alu_res == '0);
                    flag_c <= alu_c;
                end
            end
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.gpr_read  = (state == S_RD_A) || (state == S_RD_B);
    assign bus.gpr_write = (state == S_WB) && !abort_q;
    assign bus.gpr_addr  = (state == S_RD_A || bus.gpr_write) ? rd_q :
                           (state == S_RD_B)                  ? rs_q : '0;
    assign bus.gpr_wdata = bus.gpr_write ? res_q : '0;
    assign bus.done      = (state == S_WB);
    assign bus.err       = (state == S_WB) && abort_q;
    assign bus.flag_z    = flag_z;
    assign bus.flag_c    = flag_c;

endmodule

// File: doc/gpr_seq.md
# gpr_seq

Multi-cycle execution sequencer sitting directly upstream of the 10 x 10-bit general-purpose register file. It accepts one decoded instruction at a time over a valid/ready handshake, reads operands through the register file's single shared address port, computes a 10-bit result and writes it back. It also maintains zero/carry flags for the control unit.

## Interface
- `NREGS`, 10: number of implemented registers; addresses >= NREGS are illegal.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  sequencer idle, instruction accepted when `in_valid & in_ready`.
- `op`  in  3  opcode.
- `rd`  in  4  destination and first-operand register address.
- `rs`  in  4  second-operand register address.
- `imm`  in  10  immediate for LDI.
- `gpr_addr`  out  4  register file address.
- `gpr_read`  out  1  register file read enable.
- `gpr_write`  out  1  register file write enable.
- `gpr_wdata`  out  10  register file write data.
- `gpr_rdata`  in  10  register file read data, valid combinationally while `gpr_read` = 1.
- `done`  out  1  one-cycle pulse at the writeback or abort cycle.
- `err`  out  1  one-cycle pulse, illegal address or opcode.
- `flag_z`, `flag_c`  out  1 each  zero and carry flags.

## Operation
- Opcodes:
  - 000 MOV rd<-rs.
  - 001 ADD rd<-rd+rs.
  - 010 SUB rd<-rd-rs.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 LDI rd<-imm.
  - 111 MUL rd<-low 10 bits of rd*rs (see Configuration).
- FSM states: IDLE, RD_A, RD_B, EXEC, WB.
  - IDLE: `in_ready`=1. On accept, latch op/rd/rs/imm. Next state is EXEC for LDI, RD_B for MOV, otherwise RD_A.
  - RD_A: `gpr_addr`=rd, `gpr_read`=1; latch A from `gpr_rdata` at the clock edge.
  - RD_B: `gpr_addr`=rs, `gpr_read`=1; latch B.
  - EXEC: compute and register the result and the new flags.
  - WB: `gpr_addr`=rd, `gpr_write`=1, `gpr_wdata`=result, `done`=1; then go to IDLE.
- Arithmetic is 10-bit unsigned with wrap-around.
  - ADD: C = bit 10 of the 11-bit sum.
  - SUB: C = borrow, i.e. 1 when A < B.
  - AND/OR/XOR/MUL: C = 0.
  - Z = (result == 0).
- Flags update in EXEC for ADD, SUB, AND, OR, XOR and MUL only. MOV and LDI leave the flags unchanged.
- Illegal address: rd >= NREGS, or rs >= NREGS for ops that read rs. The check is made at accept time. On an illegal address, go straight from IDLE to WB-abort: `done`=1 and `err`=1 for one cycle, no register access, flags unchanged, then return to IDLE.
- `gpr_read` and `gpr_write` are never both 1. In IDLE, `gpr_read` = `gpr_write` = 0 and `gpr_addr` = 0.
- `in_valid` while the sequencer is busy is ignored; the producer must hold it until accepted.
- `rst` at any cycle, including mid-instruction: next state is IDLE, the in-flight instruction is dropped with no write, and the flags clear.

## Timing
- Reset values: `in_ready`=1; `done`, `err`, `gpr_read`, `gpr_write`, `flag_z`, `flag_c` = 0; `gpr_addr`=0; `gpr_wdata`=0.
- Latency, accept edge to `done` cycle:
  - ALU ops: 4 cycles (RD_A, RD_B, EXEC, WB).
  - MOV: 3 cycles.
  - LDI: 2 cycles.
  - Abort: 1 cycle.
- `in_ready` returns to 1 in the cycle after WB, so back-to-back throughput is one instruction per latency+1 cycles.
- The register file updates at the clock edge ending WB. A read of the same register by the next instruction sees the new value with no forwarding needed.
- Flags are visible the cycle after EXEC, i.e. during WB, and hold until the next flag-updating op.

## Configuration
- `GPR_SEQ_MUL_EN` defined: opcode 111 is MUL with 4-cycle latency, a 10x10 multiply truncated to 10 bits.
- Undefined: opcode 111 is illegal and takes the abort path (`done`=`err`=1, no write). No multiplier is synthesised.

## Structure
- Shared package `gpr_seq_pkg` holds:
  - `op_e` enum for the 3-bit opcodes.
  - `state_e` enum for the FSM states.
  - `DATA_W`=10 and `ADDR_W`=4 constants.
- Natural sub-module: `gpr_seq_alu`, combinational, taking (op, A, B, imm) and producing (result, c). The FSM, operand latches and flags live in `gpr_seq`.

## Test plan
- Reset, then LDI r3<-10'h155: `done` 2 cycles after accept, r3=0x155, flags 0/0.
- r1=0x3FF, r2=0x001, ADD r1,r2: r1=0x000, Z=1, C=1, `done` 4 cycles after accept.
- r4=0x005, r5=0x007, SUB r4,r5: r4=0x3FE, Z=0, C=1. Then MOV r6,r4: r6=0x3FE, flags unchanged.
- ADD rd=12: `done`=`err`=1 in the next cycle, `gpr_write` never asserted, register contents unchanged.
- Op 111 with r7=0x020, r8=0x040: with `GPR_SEQ_MUL_EN`, r7=0x800 mod 1024=0x000, Z=1. Without it, `err`=1 and r7 unchanged.
- Assert `rst` during RD_B of an ADD: no write occurs, next cycle `in_ready`=1 and flags=0. Hold `in_valid` high throughout and check exactly one accept per instruction.
